maze_path_ctrl: RTL and testbench

Path recorder and playback controller for the maze solver's move store. Records 2-bit direction codes as a stack (push on advance, pop on backtrack), then on command replays the surviving path in forward order (oldest first) over a valid/ready stream to the result writer. Sits between the maze-walk FSM (producer) and the result/output logic (consumer). It owns the move storage and sequences all access to it.

---
 rtl/maze_path_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_maze_path_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_path_ctrl.sv
// maze_path_ctrl: move-path stack recorder with in-order valid/ready playback.
// Records direction codes as a stack during REC and replays the surviving
// path oldest-first in PLAY. Finishes with a one-cycle done pulse in FIN.
module maze_path_ctrl #(
    parameter int unsigned MAX_LENGTH = 256,
    parameter int unsigned WIDTH      = 2,
    localparam int unsigned LW        = $clog2(MAX_LENGTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             done,
    output logic             busy,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    length,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned AW = $clog2(MAX_LENGTH);

    localparam logic [1:0] ST_REC  = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [LW-1:0]    length_q,    length_d;
    logic [AW-1:0]    rd_ptr_q,    rd_ptr_d;
    logic             overflow_q,  overflow_d;
    logic             underflow_q, underflow_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_last_q,  out_last_d;
    logic             done_q,      done_d;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    logic [WIDTH-1:0] mem_q [MAX_LENGTH];

    logic             is_full;
    logic             is_empty;
    logic [LW-1:0]    len_m1;
    logic [AW-1:0]    rd_ptr_nxt;
    logic             at_last;

    assign is_full    = (length_q == LW'(MAX_LENGTH));
    assign is_empty   = (length_q == '0);
    assign len_m1     = length_q - LW'(1);
    assign rd_ptr_nxt = rd_ptr_q + AW'(1);
    assign at_last    = (LW'(rd_ptr_q) == len_m1);

    // Next-state, stack bookkeeping, memory write port and playback beat generation.
    always_comb begin
        state_d     = state_q;
        length_d    = length_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = AW'(length_q);
        wr_data     = data_in;

        if (clear) begin
            state_d     = ST_REC;
            length_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_REC: begin
                    if (start) begin
                        if (!is_empty) begin
                            state_d     = ST_PLAY;
                            rd_ptr_d    = '0;
                            out_valid_d = 1'b1;
                            out_data_d  = mem_q[0];
                            out_last_d  = (length_q == LW'(1));
                        end else begin
                            state_d = ST_FIN;
                            done_d  = 1'b1;
                        end
                    end else if (push && pop) begin
                        // Backtrack-then-advance replaces the top; on empty it is a plain push.
                        wr_en = 1'b1;
                        if (is_empty) begin
                            length_d = length_q + LW'(1);
                        end else begin
                            wr_addr = AW'(len_m1);
                        end
                    end else if (push) begin
                        if (is_full) begin
                            overflow_d = 1'b1;
                        end else begin
                            wr_en    = 1'b1;
                            length_d = length_q + LW'(1);
                        end
                    end else if (pop) begin
                        if (is_empty) begin
                            underflow_d = 1'b1;
                        end else begin
                            length_d = len_m1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (out_ready) begin
                        if (at_last) begin
                            state_d     = ST_FIN;
                            done_d      = 1'b1;
                            out_valid_d = 1'b0;
                            out_data_d  = '0;
                            out_last_d  = 1'b0;
                        end else begin
                            rd_ptr_d   = rd_ptr_nxt;
                            out_data_d = mem_q[rd_ptr_nxt];
                            out_last_d = (LW'(rd_ptr_nxt) == len_m1);
                        end
                    end
                end
                ST_FIN: begin
                    state_d = ST_REC;
                end
                default: begin
                    state_d = ST_REC;
                end
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_REC;
            length_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            length_q    <= length_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    // Move storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign busy      = (state_q == ST_PLAY);
    assign full      = is_full;
    assign empty     = is_empty;
    assign length    = length_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_maze_path_ctrl.sv
// Self-checking bench for maze_path_ctrl: table-driven record vectors plus
// hand-written playback, stall, overflow and abort sequences with a scoreboard.
module tb_maze_path_ctrl;

    localparam int unsigned TB_MAX = 12;
    localparam int unsigned TB_LW  = $clog2(TB_MAX + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             push;
    logic             pop;
    logic [1:0]       data_in;
    logic             start;
    logic             out_ready;
    logic             out_valid;
    logic [1:0]       out_data;
    logic             out_last;
    logic             done;
    logic             busy;
    logic             full;
    logic             empty;
    logic [TB_LW-1:0] length;
    logic             overflow;
    logic             underflow;

    maze_path_ctrl #(.MAX_LENGTH(TB_MAX), .WIDTH(2)) dut (
        .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop),
        .data_in(data_in), .start(start), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .done(done), .busy(busy), .full(full), .empty(empty),
        .length(length), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [1:0] model_q [$];   // reference stack
    logic [1:0] exp_q   [$];   // scoreboard of expected beats

    typedef struct {
        logic       clr;
        logic       psh;
        logic       pp;
        logic [1:0] din;
        int         exp_len;
        logic       exp_ovf;
        logic       exp_unf;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference stack behaviour for one REC-state cycle.
    task automatic model_apply(input logic clr, input logic psh, input logic pp, input logic [1:0] d);
        if (clr) model_q.delete();
        else if (psh && pp) begin
            if (model_q.size() == 0) model_q.push_back(d);
            else model_q[model_q.size()-1] = d;
        end else if (psh) begin
            if (model_q.size() < TB_MAX) model_q.push_back(d);
        end else if (pp) begin
            if (model_q.size() > 0) void'(model_q.pop_back());
        end
    endtask

    task automatic do_push(input logic [1:0] d);
        push = 1'b1; data_in = d;
        model_apply(1'b0, 1'b1, 1'b0, d);
        step();
        push = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        model_apply(1'b1, 1'b0, 1'b0, 2'd0);
        step();
        clear = 1'b0;
    endtask

    task automatic load_scoreboard();
        exp_q.delete();
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
    endtask

    // mode 0: ready held high; mode 1: ready 1,0,0 repeating with push/pop noise.
    task automatic run_play(input string tag, input int mode, input int exp_done_cyc);
        int         cyc;
        logic       seen_done;
        logic       stalled;
        logic [1:0] held;
        logic [1:0] got;
        load_scoreboard();
        start = 1'b1;
        step();
        start = 1'b0;
        seen_done = 1'b0;
        stalled   = 1'b0;
        held      = 2'd0;
        cyc       = 0;
        while (!seen_done && cyc < 200) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (stalled) begin
                check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_stall_hold"}, 32'(out_data), 32'(held));
            end
            if (done) begin
                seen_done = 1'b1;
                push = 1'b0; pop = 1'b0;
                check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
                check({tag, "_done_left"}, 32'(exp_q.size()), 32'd0);
                if (exp_done_cyc >= 0) check({tag, "_done_cyc"}, 32'(cyc), 32'(exp_done_cyc));
            end else begin
                if (cyc == 0 && exp_q.size() > 0) check({tag, "_busy"}, 32'(busy), 32'd1);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL %s_extra_beat: got data %0d expected no beat", tag, out_data);
                    end else begin
                        got = exp_q.pop_front();
                        check({tag, "_data"}, 32'(out_data), 32'(got));
                        check({tag, "_last"}, 32'(out_last), 32'(exp_q.size() == 0));
                    end
                end
                if (mode == 1) begin
                    push = 1'b1; pop = cyc[0]; data_in = 2'd3;
                end
            end
            stalled = out_valid && !out_ready && !seen_done;
            held    = out_data;
            step();
            cyc++;
        end
        push = 1'b0; pop = 1'b0; out_ready = 1'b0;
        if (!seen_done) begin
            total_cnt++;
            $display("FAIL %s_timeout: done not seen within 200 cycles", tag);
        end
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    // Fill, start and take a few beats, leaving playback in progress.
    task automatic start_partial(input int n_fill, input int n_beats);
        logic [1:0] got;
        do_clear();
        for (int i = 0; i < n_fill; i++) do_push(2'((i * 3 + 1) % 4));
        load_scoreboard();
        start = 1'b1;
        step();
        start = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < n_beats; i++) begin
            check("abort_pre_valid", 32'(out_valid), 32'd1);
            got = exp_q.pop_front();
            check("abort_pre_data", 32'(out_data), 32'(got));
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0;
        data_in = 2'd0; start = 1'b0; out_ready = 1'b0;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 2'd0, 0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 2'd3, 1, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'd0, 0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 2'd2, 2, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'd3, 3, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 2'd0, 2, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 3, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 2'd2, 3, 1'b0, 1'b0};

        // Reset values
        step(); step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_length", 32'(length), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
        rst = 1'b0;
        step();

        // Start on empty: no beats, done in the following cycle
        run_play("empty_play", 0, 0);

        // Straight playback 0,1,2,3 at full rate, then replay of the same path
        for (int i = 0; i < 4; i++) do_push(2'(i));
        check("p4_length", 32'(length), 32'd4);
        run_play("p4", 0, 4);
        check("p4_len_after", 32'(length), 32'd4);
        run_play("p4_replay", 0, 4);

        // Table-driven record vectors
        for (int i = 0; i < 11; i++) begin
            clear = tbl[i].clr; push = tbl[i].psh; pop = tbl[i].pp; data_in = tbl[i].din;
            model_apply(tbl[i].clr, tbl[i].psh, tbl[i].pp, tbl[i].din);
            step();
            clear = 1'b0; push = 1'b0; pop = 1'b0;
            check($sformatf("vec%0d_length", i), 32'(length), 32'(tbl[i].exp_len));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].exp_len == 0));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(tbl[i].exp_len == TB_MAX));
            check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tbl[i].exp_ovf));
            check($sformatf("vec%0d_unf", i), 32'(underflow), 32'(tbl[i].exp_unf));
        end
        // Surviving path should replay as 1,2,2
        run_play("bt", 0, 3);

        // Overflow: one push beyond capacity is dropped and flagged
        do_clear();
        for (int i = 0; i < TB_MAX - 1; i++) do_push(2'(i % 4));
        check("fill_notfull", 32'(full), 32'd0);
        do_push(2'd1);
        check("fill_full", 32'(full), 32'd1);
        check("fill_len", 32'(length), 32'(TB_MAX));
        check("fill_ovf0", 32'(overflow), 32'd0);
        do_push(2'd2);
        check("ovf_len", 32'(length), 32'(TB_MAX));
        check("ovf_flag", 32'(overflow), 32'd1);
        run_play("fullplay", 0, TB_MAX);
        check("ovf_sticky", 32'(overflow), 32'd1);
        do_clear();
        check("clr_ovf", 32'(overflow), 32'd0);
        check("clr_len", 32'(length), 32'd0);

        // Stalled playback with push/pop noise while busy
        for (int i = 0; i < 5; i++) do_push(2'((i + 2) % 4));
        run_play("stall", 1, -1);
        check("stall_len", 32'(length), 32'd5);
        check("stall_ovf", 32'(overflow), 32'd0);
        check("stall_unf", 32'(underflow), 32'd0);

        // Async reset in the middle of a 10-entry playback
        start_partial(10, 4);
        rst = 1'b1;
        #1;
        check("rstmid_valid", 32'(out_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_len", 32'(length), 32'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        model_q.delete(); exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            check("rstmid_nodone", 32'(done), 32'd0);
            check("rstmid_novalid", 32'(out_valid), 32'd0);
            step();
        end

        // Synchronous clear in the middle of a 10-entry playback
        start_partial(10, 4);
        clear = 1'b1;
        step();
        clear = 1'b0;
        out_ready = 1'b0;
        model_q.delete(); exp_q.delete();
        check("clrmid_valid", 32'(out_valid), 32'd0);
        check("clrmid_busy", 32'(busy), 32'd0);
        check("clrmid_len", 32'(length), 32'd0);
        check("clrmid_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("clrmid_nodone", 32'(done), 32'd0);
            step();
        end

        // Recording works normally after the abort
        do_push(2'd3);
        do_push(2'd0);
        run_play("post_clr", 0, 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
